// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-board game blocks.
package memgame_pkg;

    // Pick/compare state machine states.
    typedef enum logic [2:0] {
        FIRST   = 3'd0,
        SECOND  = 3'd1,
        COMPARE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } pick_state_t;

    localparam int NUM_CELLS = 16;
    localparam int NUM_PAIRS = 8;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Winner code from the two final scores.
    function automatic logic [1:0] winner_code(input logic [3:0] s0, input logic [3:0] s1);
        logic [1:0] code;
        if (s0 > s1) begin
            code = WIN_P0;
        end else if (s1 > s0) begin
            code = WIN_P1;
        end else begin
            code = WIN_TIE;
        end
        return code;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with count enable and a registered zero flag.
// The counter stops at zero rather than wrapping.
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         zero_q;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == {W{1'b0}});
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/pair_checker.sv
// Turn and match engine for the 16-cell memory board: takes picks from the
// cursor stage, compares the two picked labels, keeps revealed/matched
// masks, per-player scores, the active player and game-over status.
module pair_checker #(
    parameter int NUM_CELLS   = memgame_pkg::NUM_CELLS,
    parameter int IDX_W       = 4,
    parameter int LABEL_W     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 select,
    input  logic [IDX_W-1:0]     cursor,
    input  logic [LABEL_W-1:0]   cursor_label,
    output logic [NUM_CELLS-1:0] revealed,
    output logic [NUM_CELLS-1:0] matched,
    output logic                 par,
    output logic                 player,
    output logic [3:0]           score0,
    output logic [3:0]           score1,
    output logic                 busy,
    output logic                 finish,
    output logic [1:0]           winner
);

    import memgame_pkg::*;

    localparam int              CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      SCORE_MAX = 4'(NUM_PAIRS);

    pick_state_t          state_q,    state_d;
    logic [NUM_CELLS-1:0] revealed_q, revealed_d;
    logic [NUM_CELLS-1:0] matched_q,  matched_d;
    logic                 par_q,      par_d;
    logic                 player_q,   player_d;
    logic [3:0]           score0_q,   score0_d;
    logic [3:0]           score1_q,   score1_d;
    logic [IDX_W-1:0]     idx_a_q,    idx_a_d;
    logic [IDX_W-1:0]     idx_b_q,    idx_b_d;
    logic [LABEL_W-1:0]   lab_a_q,    lab_a_d;
    logic [LABEL_W-1:0]   lab_b_q,    lab_b_d;
    logic [1:0]           winner_q,   winner_d;
    logic                 busy_q,     busy_d;
    logic                 finish_q,   finish_d;

    logic valid_pick_s;
    logic timer_load_s;
    logic timer_en_s;
    logic timer_zero_s;

    // A pick only counts on a face-down, unsolved cell; the state check is
    // done by the FSM, which only looks at it in FIRST and SECOND.
    assign valid_pick_s = select && !revealed_q[cursor] && !matched_q[cursor];

    hold_timer #(
        .W (CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (timer_load_s),
        .load_val_i (HOLD_LOAD),
        .en_i       (timer_en_s),
        .zero_o     (timer_zero_s)
    );

    // Next-state, mask, score and status logic for the pick/compare FSM.
    always_comb begin
        state_d      = state_q;
        revealed_d   = revealed_q;
        matched_d    = matched_q;
        par_d        = 1'b0;
        player_d     = player_q;
        score0_d     = score0_q;
        score1_d     = score1_q;
        idx_a_d      = idx_a_q;
        idx_b_d      = idx_b_q;
        lab_a_d      = lab_a_q;
        lab_b_d      = lab_b_q;
        winner_d     = winner_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;

        case (state_q)
            FIRST: begin
                if (valid_pick_s) begin
                    idx_a_d             = cursor;
                    lab_a_d             = cursor_label;
                    revealed_d[cursor]  = 1'b1;
                    state_d             = SECOND;
                end else begin
                    state_d = FIRST;
                end
            end
            SECOND: begin
                if (valid_pick_s) begin
                    idx_b_d             = cursor;
                    lab_b_d             = cursor_label;
                    revealed_d[cursor]  = 1'b1;
                    state_d             = COMPARE;
                end else begin
                    state_d = SECOND;
                end
            end
            COMPARE: begin
                if (lab_a_q == lab_b_q) begin
                    matched_d[idx_a_q]  = 1'b1;
                    matched_d[idx_b_q]  = 1'b1;
                    revealed_d[idx_a_q] = 1'b0;
                    revealed_d[idx_b_q] = 1'b0;
                    par_d               = 1'b1;
                    // Saturate defensively; a legal game never reaches the cap.
                    if (player_q == 1'b0) begin
                        if (score0_q < SCORE_MAX) begin
                            score0_d = score0_q + 4'd1;
                        end else begin
                            score0_d = score0_q;
                        end
                    end else begin
                        if (score1_q < SCORE_MAX) begin
                            score1_d = score1_q + 4'd1;
                        end else begin
                            score1_d = score1_q;
                        end
                    end
                    if (matched_d == {NUM_CELLS{1'b1}}) begin
                        state_d  = DONE;
                        winner_d = winner_code(score0_d, score1_d);
                    end else begin
                        state_d = FIRST;
                    end
                end else begin
                    state_d      = HOLD;
                    timer_load_s = 1'b1;
                end
            end
            HOLD: begin
                timer_en_s = 1'b1;
                if (timer_zero_s) begin
                    revealed_d[idx_a_q] = 1'b0;
                    revealed_d[idx_b_q] = 1'b0;
                    player_d            = ~player_q;
                    state_d             = FIRST;
                end else begin
                    state_d = HOLD;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FIRST;
            end
        endcase

        busy_d   = (state_d == COMPARE) || (state_d == HOLD);
        finish_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any pick, compare or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FIRST;
            revealed_q <= {NUM_CELLS{1'b0}};
            matched_q  <= {NUM_CELLS{1'b0}};
            par_q      <= 1'b0;
            player_q   <= 1'b0;
            score0_q   <= 4'd0;
            score1_q   <= 4'd0;
            idx_a_q    <= {IDX_W{1'b0}};
            idx_b_q    <= {IDX_W{1'b0}};
            lab_a_q    <= {LABEL_W{1'b0}};
            lab_b_q    <= {LABEL_W{1'b0}};
            winner_q   <= WIN_NONE;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            revealed_q <= revealed_d;
            matched_q  <= matched_d;
            par_q      <= par_d;
            player_q   <= player_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            idx_a_q    <= idx_a_d;
            idx_b_q    <= idx_b_d;
            lab_a_q    <= lab_a_d;
            lab_b_q    <= lab_b_d;
            winner_q   <= winner_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
        end
    end

    assign revealed = revealed_q;
    assign matched  = matched_q;
    assign par      = par_q;
    assign player   = player_q;
    assign score0   = score0_q;
    assign score1   = score1_q;
    assign busy     = busy_q;
    assign finish   = finish_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_pair_checker.sv
// Self-checking bench for pair_checker: directed game scenarios plus random
// picks, all checked cycle by cycle against a turn-level game model.
module tb_pair_checker;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        select = 1'b0;
    logic [3:0]  cursor = 4'd0;
    logic [3:0]  cursor_label;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic        par;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic        finish;
    logic [1:0]  winner;

    logic [3:0] board [16];
    assign cursor_label = board[cursor];

    pair_checker #(
        .NUM_CELLS   (16),
        .IDX_W       (4),
        .LABEL_W     (4),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .select       (select),
        .cursor       (cursor),
        .cursor_label (cursor_label),
        .revealed     (revealed),
        .matched      (matched),
        .par          (par),
        .player       (player),
        .score0       (score0),
        .score1       (score1),
        .busy         (busy),
        .finish       (finish),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: picks in progress, pending comparison, hold cycles left.
    logic [15:0] m_rev;
    logic [15:0] m_mat;
    logic        m_par;
    logic        m_player;
    int          m_s0;
    int          m_s1;
    int          picks[$];
    bit          m_cmp;
    int          m_hold;
    bit          m_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_winner();
        if (!m_done) return 2'b00;
        if (m_s0 > m_s1) return 2'b01;
        if (m_s1 > m_s0) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_rev    = 16'h0000;
        m_mat    = 16'h0000;
        m_par    = 1'b0;
        m_player = 1'b0;
        m_s0     = 0;
        m_s1     = 0;
        picks.delete();
        m_cmp    = 1'b0;
        m_hold   = 0;
        m_done   = 1'b0;
    endtask

    // One clock of the game rules, given what was presented at the edge.
    task automatic model_step(input bit sel, input int cur);
        int a;
        int b;
        m_par = 1'b0;
        if (m_done) begin
            // game over: everything frozen until reset
        end else if (m_cmp) begin
            m_cmp = 1'b0;
            a = picks[0];
            b = picks[1];
            if (board[a] == board[b]) begin
                m_mat[a] = 1'b1;
                m_mat[b] = 1'b1;
                m_rev[a] = 1'b0;
                m_rev[b] = 1'b0;
                m_par    = 1'b1;
                if (m_player) m_s1++; else m_s0++;
                picks.delete();
                if (m_mat == 16'hFFFF) m_done = 1'b1;
            end else begin
                m_hold = HOLD;
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_rev[picks[0]] = 1'b0;
                m_rev[picks[1]] = 1'b0;
                m_player = ~m_player;
                picks.delete();
            end
        end else if (sel && !m_rev[cur] && !m_mat[cur]) begin
            m_rev[cur] = 1'b1;
            picks.push_back(cur);
            if (picks.size() == 2) m_cmp = 1'b1;
        end
    endtask

    task automatic check_all();
        check_eq("revealed", revealed, m_rev);
        check_eq("matched",  matched,  m_mat);
        check_eq("par",      par,      m_par);
        check_eq("player",   player,   m_player);
        check_eq("score0",   score0,   m_s0);
        check_eq("score1",   score1,   m_s1);
        check_eq("busy",     busy,     (m_cmp || m_hold > 0));
        check_eq("finish",   finish,   m_done);
        check_eq("winner",   winner,   exp_winner());
    endtask

    // Present a pick (or idle) for one cycle, advance the model, check.
    task automatic tick(input bit sel, input int cur);
        select = sel;
        cursor = cur[3:0];
        @(posedge clk);
        model_step(sel, cur);
        #1;
        check_all();
        @(negedge clk);
        select = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20) begin
            tick(1'b0, 0);
            k++;
        end
        check_eq("idle_timeout", busy, 1'b0);
    endtask

    task automatic play_pair(input int a, input int b);
        tick(1'b1, a);
        tick(1'b1, b);
        tick(1'b0, 0);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ga5[9];
        int gb5[9];
        int gat[9];
        int gbt[9];
        int nb;
        board = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 4'd4, 4'd5, 4'd6,
                  4'd7, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd7, 4'd2};
        ga5 = '{0, 1, 2, 4, 5, 6, 6, 7, 8};
        gb5 = '{13, 15, 3, 9, 10, 7, 11, 12, 14};
        gat = '{0, 1, 2, 4, 5, 5, 6, 7, 8};
        gbt = '{13, 15, 3, 9, 6, 10, 11, 12, 14};

        // Reset then idle
        do_reset();
        repeat (10) tick(1'b0, $urandom_range(0, 15));

        // Match of cells 0 and 13: reveal latency and par latency
        do_reset();
        tick(1'b1, 0);
        check_eq("sel_to_reveal", revealed, 16'h0001);
        tick(1'b1, 13);
        check_eq("par_early", par, 1'b0);
        tick(1'b0, 0);
        check_eq("par_2cyc", par, 1'b1);
        check_eq("match_mask", matched, 16'h2001);
        check_eq("match_score0", score0, 4'd1);
        tick(1'b0, 0);
        check_eq("par_one_cycle", par, 1'b0);

        // Mismatch 0/1: busy spans the compare cycle plus HOLD cycles
        do_reset();
        tick(1'b1, 0);
        tick(1'b1, 1);
        check_eq("mismatch_reveal", revealed, 16'h0003);
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            tick((nb == 2), 7);
        end
        check_eq("busy_len", nb, HOLD + 1);
        check_eq("hold_clear", revealed, 16'h0000);
        check_eq("hold_player", player, 1'b1);

        // Duplicate pick ignored; picking a matched cell ignored
        do_reset();
        tick(1'b1, 5);
        tick(1'b1, 5);
        check_eq("dup_pick", revealed, 16'h0020);
        check_eq("dup_busy", busy, 1'b0);
        tick(1'b1, 2);
        tick(1'b0, 0);
        wait_idle();
        do_reset();
        play_pair(0, 13);
        tick(1'b1, 0);
        check_eq("matched_pick", revealed, 16'h0000);

        // Full game: player 0 wins 5-3
        do_reset();
        for (int i = 0; i < 9; i++) play_pair(ga5[i], gb5[i]);
        check_eq("full_matched", matched, 16'hFFFF);
        check_eq("full_finish", finish, 1'b1);
        check_eq("full_winner", winner, 2'b01);
        check_eq("full_s1", score1, 4'd3);
        for (int i = 0; i < 3; i++) tick(1'b1, i + 3);
        check_eq("done_frozen", winner, 2'b01);

        // Tie 4-4
        do_reset();
        for (int i = 0; i < 9; i++) play_pair(gat[i], gbt[i]);
        check_eq("tie_winner", winner, 2'b11);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        tick(1'b1, 0);
        tick(1'b1, 1);
        tick(1'b0, 0);
        tick(1'b0, 0);
        check_eq("in_hold", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("rst_hold_rev", revealed, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 0);

        // Random play, cursor wandering every cycle
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                tick(($urandom_range(0, 2) == 0), $urandom_range(0, 15));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_checker.md
Name: pair_checker

Overview:
- Turn and match engine for the 16-cell memory board.
- Consumes the cursor index and the one-cycle select pulse from the cursor/move stage, plus the label under the cursor from the board label mux.
- Tracks the first and second pick, compares labels, and maintains the revealed/matched masks that the cell and display stages consume.
- Keeps per-player scores, the active player, and game-over/winner status.

Parameters:
- NUM_CELLS, 16, number of board cells; must equal 2^IDX_W.
- IDX_W, 4, width of the cursor index.
- LABEL_W, 4, width of a cell label.
- HOLD_CYCLES, 50_000_000, cycles that a mismatched pair stays revealed (1 s at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- select  in  1  one-cycle pick pulse, synchronous to clk.
- cursor  in  IDX_W  cell index under the cursor, valid whenever select=1.
- cursor_label  in  LABEL_W  label of the cell at cursor, combinational from the board.
- revealed  out  NUM_CELLS  bit i=1 means cell i is currently face-up and not yet matched.
- matched  out  NUM_CELLS  bit i=1 means cell i is permanently solved.
- par  out  1  one-cycle pulse on a successful match.
- player  out  1  active player (0 or 1).
- score0  out  4  pairs won by player 0.
- score1  out  4  pairs won by player 1.
- busy  out  1  1 in COMPARE and HOLD; select is ignored while busy.
- finish  out  1  1 in DONE.
- winner  out  2  valid only in DONE: 01 = player 0, 10 = player 1, 11 = tie; 00 otherwise.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FIRST; revealed=0; matched=0; par=0; player=0.
  - score0=0; score1=0; busy=0; finish=0; winner=00; hold counter=0.
  - Reset mid-HOLD or mid-compare aborts immediately; nothing is retained.
- Valid pick: select=1, state is FIRST or SECOND, revealed[cursor]=0 and matched[cursor]=0. Any other select is ignored with no state change.
- FIRST: on a valid pick, latch idx_a=cursor and lab_a=cursor_label; set revealed[cursor]; go to SECOND next cycle.
- SECOND: on a valid pick, latch idx_b and lab_b; set revealed[cursor]; go to COMPARE. Picking idx_a again is invalid (already revealed) and is ignored.
- COMPARE (1 cycle):
  - Labels equal: set matched[idx_a] and matched[idx_b]; clear both revealed bits; pulse par for 1 cycle; increment the active player's score; player unchanged.
    - If matched becomes all-ones, go to DONE; otherwise go to FIRST.
  - Labels differ: go to HOLD; load the counter with HOLD_CYCLES-1.
- HOLD:
  - Decrement the counter each cycle.
  - When it reaches 0: clear revealed[idx_a] and revealed[idx_b]; toggle player; go to FIRST.
  - Total time revealed in HOLD is exactly HOLD_CYCLES cycles.
- DONE:
  - finish=1; winner computed from score0 vs score1 and held.
  - All select pulses are ignored. Exit only by reset.
- Latency:
  - Select to revealed bit set: 1 cycle.
  - Second select to par pulse: 2 cycles (SECOND→COMPARE register, then the par register).
- Scores: 4-bit unsigned, maximum 8, so no wrap is possible. A score never exceeds 8, and score0+score1 never exceeds 8.
- Simultaneous events:
  - A select in the same cycle as the COMPARE→FIRST transition is ignored, because the state is still COMPARE.
  - The cursor may change at any time; only the value sampled with a valid select matters.
- Board labels are fixed and supplied externally; the block never stores the label map.

Decomposition:
- Shared package memgame_pkg holds:
  - typedef enum logic [2:0] {FIRST, SECOND, COMPARE, HOLD, DONE} pick_state_t;
  - constants NUM_CELLS=16, NUM_PAIRS=8, winner codes WIN_P0=2'b01, WIN_P1=2'b10, WIN_TIE=2'b11.
- One sub-module, hold_timer: a loadable down-counter with load, count-enable and a zero flag, parameterised by width. Instantiate it once.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, run 10 cycles with no select → revealed=0, matched=0, score0=score1=0, player=0, finish=0, busy=0.
- Match (label 1 at idx 0 and idx 13): select idx 0, then select idx 13 → par pulses 1 cycle, 2 cycles after the second select; matched=16'h2001; revealed=0; score0=1; player=0.
- Mismatch with HOLD_CYCLES=4: select idx 0 (label 1), then idx 1 (label 2) → revealed=16'h0003, busy=1 for exactly 4 HOLD cycles; then revealed=0, player=1, scores unchanged.
- Ignored picks:
  - Select idx 5 twice → second select ignored, state stays SECOND.
  - Select an already matched cell → ignored.
  - Select during HOLD → ignored; revealed unchanged.
- Full game: solve all 8 pairs with player 0 winning 5 and player 1 winning 3 → matched=16'hFFFF, finish=1, winner=01; further selects cause no change.
- Tie and reset mid-HOLD:
  - Play to a 4–4 result → winner=11.
  - Separately, assert rst during HOLD → all outputs return to reset values on the same edge.
